// File: rtl/memcpy_burst_arbiter.sv
// memcpy_burst_arbiter: round-robin sharing of one burst engine across NUM_REQ sequencers.
// Define MEMCPY_ARB_STATS_EN to add per-slot grant counters on grant_cnt.
module memcpy_burst_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 64,
   parameter int LEN_W   = 8,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_start,
   input  logic [NUM_REQ*LEN_W-1:0]  req_len,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        req_busy,
   output logic [NUM_REQ-1:0]        req_done,
   output logic [NUM_REQ-1:0]        req_err,
   output logic                      burst_start,
   output logic [LEN_W-1:0]          burst_len,
   output logic [ADDR_W-1:0]         burst_addr,
   output logic [ID_W-1:0]           burst_owner,
`ifdef MEMCPY_ARB_STATS_EN
   output logic [NUM_REQ*32-1:0]     grant_cnt,
`endif
   input  logic                      burst_done
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t             state;
   logic [NUM_REQ-1:0] pending;
   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    owner;
   logic [ID_W-1:0]    sel;
   logic [ID_W-1:0]    cand;
   logic [ID_W-1:0]    sel_nxt;
   logic [ID_W-1:0]    owner_nxt;
   logic               found;
   int                 idx;

   logic [LEN_W-1:0]   slot_len  [NUM_REQ];
   logic [ADDR_W-1:0]  slot_addr [NUM_REQ];

`ifdef MEMCPY_ARB_STATS_EN
   logic [31:0]        cnt [NUM_REQ];

   always_comb begin
      grant_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++)
         grant_cnt[i*32 +: 32] = cnt[i];
   end
`endif

   // First pending slot at or above the pointer, wrapping.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ)
            idx = idx - NUM_REQ;
         cand = ID_W'(idx);
         if (!found && pending[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   assign sel_nxt   = (sel == ID_W'(NUM_REQ-1))   ? '0 : sel + 1'b1;
   assign owner_nxt = (owner == ID_W'(NUM_REQ-1)) ? '0 : owner + 1'b1;

   always_comb begin
      req_busy = pending;
      if (state == S_WAIT)
         req_busy[owner] = 1'b1;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_start[i] && !req_busy[i]) begin
            slot_len[i]  <= req_len[i*LEN_W +: LEN_W];
            slot_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         pending     <= '0;
         ptr         <= '0;
         owner       <= '0;
         req_done    <= '0;
         req_err     <= '0;
         burst_start <= 1'b0;
         burst_len   <= '0;
         burst_addr  <= '0;
         burst_owner <= '0;
`ifdef MEMCPY_ARB_STATS_EN
         for (int i = 0; i < NUM_REQ; i++)
            cnt[i] <= '0;
`endif
      end else begin
         burst_start <= 1'b0;
         req_done    <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_start[i]) begin
               if (req_busy[i])
                  req_err[i] <= 1'b1;
               else
                  pending[i] <= 1'b1;
            end
         end
         case (state)
            S_IDLE: begin
               if (found) begin
                  pending[sel] <= 1'b0;
                  owner        <= sel;
                  if (slot_len[sel] != '0) begin
                     burst_start <= 1'b1;
                     burst_len   <= slot_len[sel];
                     burst_addr  <= slot_addr[sel];
                     burst_owner <= sel;
                     state       <= S_WAIT;
`ifdef MEMCPY_ARB_STATS_EN
                     cnt[sel]    <= cnt[sel] + 32'd1;
`endif
                  end else begin
                     req_done[sel] <= 1'b1;
                     ptr           <= sel_nxt;
                  end
               end
            end
            S_WAIT: begin
               if (burst_done) begin
                  req_done[owner] <= 1'b1;
                  ptr             <= owner_nxt;
                  state           <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memcpy_burst_arbiter.sv
// tb_memcpy_burst_arbiter: directed vector table plus hand sequences for
// ordering, fairness and reset-in-burst.
module tb_memcpy_burst_arbiter;

   logic         clk;
   logic         rst;
   logic [1:0]   req_start;
   logic [15:0]  req_len;
   logic [127:0] req_addr;
   logic [1:0]   req_busy;
   logic [1:0]   req_done;
   logic [1:0]   req_err;
   logic         burst_start;
   logic [7:0]   burst_len;
   logic [63:0]  burst_addr;
   logic         burst_owner;
   logic         burst_done;
`ifdef MEMCPY_ARB_STATS_EN
   logic [63:0]  grant_cnt;
`endif

   int checks;
   int failures;

   memcpy_burst_arbiter #(
      .NUM_REQ(2),
      .ADDR_W (64),
      .LEN_W  (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_start  (req_start),
      .req_len    (req_len),
      .req_addr   (req_addr),
      .req_busy   (req_busy),
      .req_done   (req_done),
      .req_err    (req_err),
      .burst_start(burst_start),
      .burst_len  (burst_len),
      .burst_addr (burst_addr),
      .burst_owner(burst_owner),
`ifdef MEMCPY_ARB_STATS_EN
      .grant_cnt  (grant_cnt),
`endif
      .burst_done (burst_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  st;
      logic [7:0]  l0;
      logic [7:0]  l1;
      logic [63:0] a0;
      logic [63:0] a1;
      logic        bd;
      logic        e_bs;
      logic [7:0]  e_len;
      logic [63:0] e_addr;
      logic        e_own;
      logic [1:0]  e_busy;
      logic [1:0]  e_done;
      logic [1:0]  e_err;
   } vec_t;

   vec_t tbl [13];

   function automatic vec_t mk(logic [1:0] st, logic [7:0] l0, logic [7:0] l1,
                               logic [63:0] a0, logic [63:0] a1, logic bd,
                               logic e_bs, logic [7:0] e_len, logic [63:0] e_addr,
                               logic e_own, logic [1:0] e_busy, logic [1:0] e_done,
                               logic [1:0] e_err);
      vec_t v;
      v.st = st; v.l0 = l0; v.l1 = l1; v.a0 = a0; v.a1 = a1; v.bd = bd;
      v.e_bs = e_bs; v.e_len = e_len; v.e_addr = e_addr; v.e_own = e_own;
      v.e_busy = e_busy; v.e_done = e_done; v.e_err = e_err;
      return v;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask

   // One clock; pulse inputs drop right after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      req_start  = '0;
      burst_done = 1'b0;
   endtask

   task automatic reset_dut();
      rst        = 1'b1;
      req_start  = '0;
      burst_done = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_bs(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 8 && !ok; i++) begin
         tick();
         if (burst_start) ok = 1'b1;
      end
   endtask

   bit      ok;
   logic    own [3];

   initial begin
      checks     = 0;
      failures   = 0;
      req_len    = '0;
      req_addr   = '0;
      reset_dut();

      check("rst_bs",    64'(burst_start), 64'd0);
      check("rst_len",   64'(burst_len),   64'd0);
      check("rst_addr",  burst_addr,       64'd0);
      check("rst_owner", 64'(burst_owner), 64'd0);
      check("rst_busy",  64'(req_busy),    64'd0);
      check("rst_done",  64'(req_done),    64'd0);
      check("rst_err",   64'(req_err),     64'd0);

      // single burst, zero length, overlap error
      tbl[0]  = mk(2'b01, 8'd4, 8'd0, 64'h1000, 64'h0, 0, 0, 8'd0, 64'h0,    0, 2'b01, 2'b00, 2'b00);
      tbl[1]  = mk(2'b00, 8'd4, 8'd0, 64'h1000, 64'h0, 0, 1, 8'd4, 64'h1000, 0, 2'b01, 2'b00, 2'b00);
      tbl[2]  = mk(2'b00, 8'd4, 8'd0, 64'h1000, 64'h0, 0, 0, 8'd4, 64'h1000, 0, 2'b01, 2'b00, 2'b00);
      tbl[3]  = mk(2'b00, 8'd4, 8'd0, 64'h1000, 64'h0, 1, 0, 8'd4, 64'h1000, 0, 2'b00, 2'b01, 2'b00);
      tbl[4]  = mk(2'b00, 8'd4, 8'd0, 64'h1000, 64'h0, 0, 0, 8'd4, 64'h1000, 0, 2'b00, 2'b00, 2'b00);
      tbl[5]  = mk(2'b10, 8'd4, 8'd0, 64'h1000, 64'h2000, 0, 0, 8'd4, 64'h1000, 0, 2'b10, 2'b00, 2'b00);
      tbl[6]  = mk(2'b00, 8'd4, 8'd0, 64'h1000, 64'h2000, 0, 0, 8'd4, 64'h1000, 0, 2'b00, 2'b10, 2'b00);
      tbl[7]  = mk(2'b00, 8'd4, 8'd0, 64'h1000, 64'h2000, 0, 0, 8'd4, 64'h1000, 0, 2'b00, 2'b00, 2'b00);
      tbl[8]  = mk(2'b01, 8'd8, 8'd0, 64'h3000, 64'h2000, 0, 0, 8'd4, 64'h1000, 0, 2'b01, 2'b00, 2'b00);
      tbl[9]  = mk(2'b01, 8'h55, 8'd0, 64'h9999, 64'h2000, 0, 1, 8'd8, 64'h3000, 0, 2'b01, 2'b00, 2'b01);
      tbl[10] = mk(2'b01, 8'h55, 8'd0, 64'h9999, 64'h2000, 0, 0, 8'd8, 64'h3000, 0, 2'b01, 2'b00, 2'b01);
      tbl[11] = mk(2'b00, 8'h55, 8'd0, 64'h9999, 64'h2000, 1, 0, 8'd8, 64'h3000, 0, 2'b00, 2'b01, 2'b01);
      tbl[12] = mk(2'b00, 8'h55, 8'd0, 64'h9999, 64'h2000, 0, 0, 8'd8, 64'h3000, 0, 2'b00, 2'b00, 2'b01);

      for (int s = 0; s < 13; s++) begin
         req_start  = tbl[s].st;
         req_len    = {tbl[s].l1, tbl[s].l0};
         req_addr   = {tbl[s].a1, tbl[s].a0};
         burst_done = tbl[s].bd;
         tick();
         check($sformatf("v%0d_bs", s),    64'(burst_start), 64'(tbl[s].e_bs));
         check($sformatf("v%0d_len", s),   64'(burst_len),   64'(tbl[s].e_len));
         check($sformatf("v%0d_addr", s),  burst_addr,       tbl[s].e_addr);
         check($sformatf("v%0d_owner", s), 64'(burst_owner), 64'(tbl[s].e_own));
         check($sformatf("v%0d_busy", s),  64'(req_busy),    64'(tbl[s].e_busy));
         check($sformatf("v%0d_done", s),  64'(req_done),    64'(tbl[s].e_done));
         check($sformatf("v%0d_err", s),   64'(req_err),     64'(tbl[s].e_err));
      end

      // simultaneous starts: slot0 first, slot1 two cycles after burst_done
      reset_dut();
      req_len   = {8'd3, 8'd2};
      req_addr  = {64'hB0, 64'hA0};
      req_start = 2'b11;
      tick();
      check("sim_busy", 64'(req_busy), 64'd3);
      wait_bs(ok);
      check("sim_bs0_seen", 64'(ok), 64'd1);
      check("sim_owner0", 64'(burst_owner), 64'd0);
      check("sim_len0", 64'(burst_len), 64'd2);
      check("sim_addr0", burst_addr, 64'hA0);
      tick();
      burst_done = 1'b1;
      tick();
      check("sim_done0", 64'(req_done), 64'd1);
      check("sim_bs_gap", 64'(burst_start), 64'd0);
      tick();
      check("sim_bs1", 64'(burst_start), 64'd1);
      check("sim_owner1", 64'(burst_owner), 64'd1);
      check("sim_len1", 64'(burst_len), 64'd3);
      check("sim_addr1", burst_addr, 64'hB0);
      burst_done = 1'b1;
      tick();
      check("sim_done1", 64'(req_done), 64'd2);
`ifdef MEMCPY_ARB_STATS_EN
      check("sim_cnt", grant_cnt, {32'd1, 32'd1});
`endif

      // fairness: slot0 keeps re-requesting, slot1 asks once
      reset_dut();
      req_len   = {8'd1, 8'd1};
      req_addr  = {64'hD0, 64'hC0};
      req_start = 2'b11;
      tick();
      for (int g = 0; g < 3; g++) begin
         wait_bs(ok);
         check($sformatf("fair_bs%0d_seen", g), 64'(ok), 64'd1);
         own[g] = burst_owner;
         tick();
         burst_done = 1'b1;
         tick();
         check($sformatf("fair_done%0d", g), 64'(req_done != 2'b00), 64'd1);
         if (req_done[0] && g < 2) req_start = 2'b01;
      end
      check("fair_g0", 64'(own[0]), 64'd0);
      check("fair_g1", 64'(own[1]), 64'd1);
      check("fair_g2", 64'(own[2]), 64'd0);

      // reset while a burst is outstanding
      reset_dut();
      req_len   = {8'd0, 8'd5};
      req_addr  = {64'h0, 64'hE0};
      req_start = 2'b01;
      tick();
      wait_bs(ok);
      check("rw_bs_seen", 64'(ok), 64'd1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rw_len", 64'(burst_len), 64'd0);
      check("rw_addr", burst_addr, 64'd0);
      check("rw_busy", 64'(req_busy), 64'd0);
`ifdef MEMCPY_ARB_STATS_EN
      check("rw_cnt", grant_cnt, 64'd0);
`endif
      burst_done = 1'b1;
      tick();
      check("rw_done_a", 64'(req_done), 64'd0);
      tick();
      check("rw_done_b", 64'(req_done), 64'd0);
      check("rw_bs", 64'(burst_start), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
